// File: rtl/axi_pkg.sv
// Shared response codes and FSM state encodings for the single-beat AXI slave memory.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

endpackage

// File: rtl/axi_slave_regfile.sv
// Word storage with a byte-strobed write port and a captured read port.
// A read and a write to the same word on one edge returns the pre-write contents.
module axi_slave_regfile #(
    parameter int DATA_BITS = 32,
    parameter int DEPTH     = 16,
    parameter int IDX_BITS  = $clog2(DEPTH)
) (
    input  logic                   aclk,
    input  logic                   areset_n,
    input  logic                   we,
    input  logic [IDX_BITS-1:0]    waddr,
    input  logic [DATA_BITS-1:0]   wdata,
    input  logic [DATA_BITS/8-1:0] wstrb,
    input  logic                   re,
    input  logic                   rzero,
    input  logic [IDX_BITS-1:0]    raddr,
    output logic [DATA_BITS-1:0]   rdata
);

    localparam int STRB_BITS = DATA_BITS / 8;

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [DATA_BITS-1:0] mem_d [DEPTH];
    logic [DATA_BITS-1:0] rdata_q;
    logic [DATA_BITS-1:0] rdata_d;

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            for (int b = 0; b < STRB_BITS; b++) begin
                if (wstrb[b]) begin
                    mem_d[waddr][8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end
    end

    // Out-of-range reads capture zero instead of aliasing onto a real word.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = rzero ? '0 : mem_q[raddr];
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            mem_q   <= '{default: '0};
            rdata_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/axi_slave_mem.sv
// Single-beat AXI slave backed by a small word memory; independent read and write FSMs
// with registered handshake outputs.
module axi_slave_mem
    import axi_pkg::*;
#(
    parameter int DATA_BITS = 32,
    parameter int ADDR_BITS = 32,
    parameter int DEPTH     = 16
) (
    input  logic                   aclk,
    input  logic                   areset_n,
    input  logic                   aw_valid,
    output logic                   aw_ready,
    input  logic [ADDR_BITS-1:0]   aw_addr,
    input  logic                   w_valid,
    output logic                   w_ready,
    input  logic [DATA_BITS-1:0]   w_data,
    input  logic [DATA_BITS/8-1:0] w_strb,
    output logic                   b_valid,
    input  logic                   b_ready,
    output logic [1:0]             b_resp,
    input  logic                   ar_valid,
    output logic                   ar_ready,
    input  logic [ADDR_BITS-1:0]   ar_addr,
    output logic                   r_valid,
    input  logic                   r_ready,
    output logic [DATA_BITS-1:0]   r_data,
    output logic [1:0]             r_resp
);

    localparam int STRB_BITS  = DATA_BITS / 8;
    localparam int BYTE_SHIFT = $clog2(STRB_BITS);
    localparam int IDX_BITS   = $clog2(DEPTH);

    function automatic logic addr_ok(input logic [ADDR_BITS-1:0] a);
        return (a >> (BYTE_SHIFT + IDX_BITS)) == '0;
    endfunction

    function automatic logic [IDX_BITS-1:0] idx_of(input logic [ADDR_BITS-1:0] a);
        return a[BYTE_SHIFT +: IDX_BITS];
    endfunction

    w_state_e               w_state_q, w_state_d;
    logic [ADDR_BITS-1:0]   awaddr_q, awaddr_d;
    logic [DATA_BITS-1:0]   wdata_q, wdata_d;
    logic [STRB_BITS-1:0]   wstrb_q, wstrb_d;
    logic [1:0]             b_resp_q, b_resp_d;
    logic                   aw_ready_q, aw_ready_d;
    logic                   w_ready_q, w_ready_d;
    logic                   b_valid_q, b_valid_d;

    r_state_e               r_state_q, r_state_d;
    logic [1:0]             r_resp_q, r_resp_d;
    logic                   ar_ready_q, ar_ready_d;
    logic                   r_valid_q, r_valid_d;

    logic                   aw_hs, w_hs, ar_hs;
    logic                   commit;
    logic [ADDR_BITS-1:0]   cm_addr;
    logic [DATA_BITS-1:0]   cm_data;
    logic [STRB_BITS-1:0]   cm_strb;
    logic                   mem_we, rd_en, rd_zero;
    logic [IDX_BITS-1:0]    mem_waddr, mem_raddr;

    assign aw_hs = aw_valid && aw_ready_q;
    assign w_hs  = w_valid && w_ready_q;
    assign ar_hs = ar_valid && ar_ready_q;

    // cm_* selects whichever half of the write was latched earlier versus arriving now.
    always_comb begin
        w_state_d = w_state_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        b_resp_d  = b_resp_q;
        commit    = 1'b0;
        cm_addr   = aw_addr;
        cm_data   = w_data;
        cm_strb   = w_strb;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit    = 1'b1;
                    w_state_d = W_RESP;
                end else if (aw_hs) begin
                    awaddr_d  = aw_addr;
                    w_state_d = W_ADDR;
                end else if (w_hs) begin
                    wdata_d   = w_data;
                    wstrb_d   = w_strb;
                    w_state_d = W_DATA;
                end
            end
            W_ADDR: begin
                if (w_hs) begin
                    commit    = 1'b1;
                    cm_addr   = awaddr_q;
                    w_state_d = W_RESP;
                end
            end
            W_DATA: begin
                if (aw_hs) begin
                    commit    = 1'b1;
                    cm_data   = wdata_q;
                    cm_strb   = wstrb_q;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (b_valid_q && b_ready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        if (commit) begin
            b_resp_d = addr_ok(cm_addr) ? RESP_OKAY : RESP_SLVERR;
        end
        aw_ready_d = (w_state_d == W_IDLE) || (w_state_d == W_DATA);
        w_ready_d  = (w_state_d == W_IDLE) || (w_state_d == W_ADDR);
        b_valid_d  = (w_state_d == W_RESP);
    end

    always_comb begin
        r_state_d = r_state_q;
        r_resp_d  = r_resp_q;
        rd_en     = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rd_en     = 1'b1;
                    r_resp_d  = addr_ok(ar_addr) ? RESP_OKAY : RESP_SLVERR;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (r_valid_q && r_ready) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        ar_ready_d = (r_state_d == R_IDLE);
        r_valid_d  = (r_state_d == R_DATA);
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            w_state_q  <= W_IDLE;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            b_resp_q   <= '0;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            r_state_q  <= R_IDLE;
            r_resp_q   <= '0;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
        end else begin
            w_state_q  <= w_state_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            b_resp_q   <= b_resp_d;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            b_valid_q  <= b_valid_d;
            r_state_q  <= r_state_d;
            r_resp_q   <= r_resp_d;
            ar_ready_q <= ar_ready_d;
            r_valid_q  <= r_valid_d;
        end
    end

    assign mem_we    = commit && addr_ok(cm_addr);
    assign mem_waddr = idx_of(cm_addr);
    assign mem_raddr = idx_of(ar_addr);
    assign rd_zero   = !addr_ok(ar_addr);

    axi_slave_regfile #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (DEPTH),
        .IDX_BITS  (IDX_BITS)
    ) u_regfile (
        .aclk     (aclk),
        .areset_n (areset_n),
        .we       (mem_we),
        .waddr    (mem_waddr),
        .wdata    (cm_data),
        .wstrb    (cm_strb),
        .re       (rd_en),
        .rzero    (rd_zero),
        .raddr    (mem_raddr),
        .rdata    (r_data)
    );

    assign aw_ready = aw_ready_q;
    assign w_ready  = w_ready_q;
    assign b_valid  = b_valid_q;
    assign b_resp   = b_resp_q;
    assign ar_ready = ar_ready_q;
    assign r_valid  = r_valid_q;
    assign r_resp   = r_resp_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: a vector table of single-beat accesses plus
// hand sequences for split handshakes, back-pressure, read/write collision and reset abort.
module tb_axi_slave_mem;

    logic        aclk = 1'b0;
    logic        areset_n = 1'b1;
    logic        aw_valid = 1'b0, aw_ready;
    logic [31:0] aw_addr = '0;
    logic        w_valid = 1'b0, w_ready;
    logic [31:0] w_data = '0;
    logic [3:0]  w_strb = '0;
    logic        b_valid, b_ready = 1'b0;
    logic [1:0]  b_resp;
    logic        ar_valid = 1'b0, ar_ready;
    logic [31:0] ar_addr = '0;
    logic        r_valid, r_ready = 1'b0;
    logic [31:0] r_data;
    logic [1:0]  r_resp;

    int checks = 0;
    int failures = 0;

    always #5 aclk = ~aclk;

    axi_slave_mem #(.DATA_BITS(32), .ADDR_BITS(32), .DEPTH(16)) dut (
        .aclk(aclk), .areset_n(areset_n),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp)
    );

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] resp);
        int n = 0;
        aw_valid = 1'b1; aw_addr = addr;
        w_valid  = 1'b1; w_data = data; w_strb = strb;
        while (!(aw_ready && w_ready) && n < 20) begin tick(); n++; end
        chk("wr_ready_wait", 32'(n < 20), 32'd1);
        tick();
        aw_valid = 1'b0; w_valid = 1'b0;
        chk("wr_b_valid", 32'(b_valid), 32'd1);
        chk("wr_b_resp", 32'(b_resp), 32'(resp));
        $display("WR addr=%h data=%h strb=%h b_resp=%b", addr, data, strb, b_resp);
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        chk("wr_b_done", 32'(b_valid), 32'd0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
        int n = 0;
        ar_valid = 1'b1; ar_addr = addr;
        while (!ar_ready && n < 20) begin tick(); n++; end
        chk("rd_ready_wait", 32'(n < 20), 32'd1);
        tick();
        ar_valid = 1'b0;
        chk("rd_r_valid", 32'(r_valid), 32'd1);
        chk("rd_r_data", r_data, data);
        chk("rd_r_resp", 32'(r_resp), 32'(resp));
        $display("RD addr=%h r_data=%h r_resp=%b", addr, r_data, r_resp);
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        chk("rd_r_done", 32'(r_valid), 32'd0);
        chk("rd_ar_ready_back", 32'(ar_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] held;
        vecs[0]  = '{1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 2'b00};
        vecs[1]  = '{1'b0, 32'h04, 32'hDEADBEEF, 4'h0, 2'b00};
        vecs[2]  = '{1'b1, 32'h0C, 32'h11223344, 4'hF, 2'b00};
        vecs[3]  = '{1'b1, 32'h0C, 32'hAABBCCDD, 4'h5, 2'b00};
        vecs[4]  = '{1'b0, 32'h0C, 32'h11BB33DD, 4'h0, 2'b00};
        vecs[5]  = '{1'b1, 32'h40, 32'h12345678, 4'hF, 2'b10};
        vecs[6]  = '{1'b0, 32'h40, 32'h00000000, 4'h0, 2'b10};
        vecs[7]  = '{1'b0, 32'h44, 32'h00000000, 4'h0, 2'b10};
        vecs[8]  = '{1'b0, 32'h00, 32'h00000000, 4'h0, 2'b00};
        vecs[9]  = '{1'b0, 32'h3C, 32'h00000000, 4'h0, 2'b00};
        vecs[10] = '{1'b1, 32'h3C, 32'hCAFEF00D, 4'hF, 2'b00};
        vecs[11] = '{1'b0, 32'h3C, 32'hCAFEF00D, 4'h0, 2'b00};
        vecs[12] = '{1'b1, 32'h07, 32'h0000AA00, 4'h2, 2'b00};
        vecs[13] = '{1'b0, 32'h04, 32'hDEADAAEF, 4'h0, 2'b00};
        vecs[14] = '{1'b0, 32'h08, 32'h00000000, 4'h0, 2'b00};
        vecs[15] = '{1'b0, 32'h3C, 32'hCAFEF00D, 4'h0, 2'b00};

        // Reset state
        #1 areset_n = 1'b0;
        #2;
        chk("rst_aw_ready", 32'(aw_ready), 32'd0);
        chk("rst_w_ready", 32'(w_ready), 32'd0);
        chk("rst_ar_ready", 32'(ar_ready), 32'd0);
        chk("rst_b_valid", 32'(b_valid), 32'd0);
        chk("rst_r_valid", 32'(r_valid), 32'd0);
        chk("rst_r_data", r_data, 32'd0);
        tick(); tick();
        areset_n = 1'b1;
        tick();
        chk("idle_aw_ready", 32'(aw_ready), 32'd1);
        chk("idle_w_ready", 32'(w_ready), 32'd1);
        chk("idle_ar_ready", 32'(ar_ready), 32'd1);

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp);
            else               do_read(vecs[i].addr, vecs[i].data, vecs[i].resp);
        end

        // W three cycles ahead of AW
        w_valid = 1'b1; w_data = 32'h5A5A0F0F; w_strb = 4'hF;
        tick();
        w_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("wfirst_aw_ready", 32'(aw_ready), 32'd1);
            chk("wfirst_w_ready", 32'(w_ready), 32'd0);
            chk("wfirst_no_b", 32'(b_valid), 32'd0);
            if (i < 2) tick();
        end
        aw_valid = 1'b1; aw_addr = 32'h08;
        tick();
        aw_valid = 1'b0;
        chk("wfirst_b_valid", 32'(b_valid), 32'd1);
        chk("wfirst_b_resp", 32'(b_resp), 32'd0);
        $display("WR (W before AW) addr=00000008 data=5a5a0f0f b_resp=%b", b_resp);
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("wfirst_single_b", 32'(b_valid), 32'd0);
            tick();
        end
        do_read(32'h08, 32'h5A5A0F0F, 2'b00);

        // Read and write of the same word on one edge: read sees the old word
        aw_valid = 1'b1; aw_addr = 32'h3C; w_valid = 1'b1; w_data = 32'h01020304; w_strb = 4'hF;
        ar_valid = 1'b1; ar_addr = 32'h3C;
        tick();
        aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
        chk("coll_b_valid", 32'(b_valid), 32'd1);
        chk("coll_r_valid", 32'(r_valid), 32'd1);
        chk("coll_r_data_old", r_data, 32'hCAFEF00D);
        $display("RD+WR same edge addr=0000003c r_data=%h", r_data);
        b_ready = 1'b1; r_ready = 1'b1;
        tick();
        b_ready = 1'b0; r_ready = 1'b0;
        do_read(32'h3C, 32'h01020304, 2'b00);

        // B back-pressure while reads proceed, then R back-pressure for 5 cycles
        aw_valid = 1'b1; aw_addr = 32'h10; w_valid = 1'b1; w_data = 32'h0BADF00D; w_strb = 4'hF;
        tick();
        aw_valid = 1'b0; w_valid = 1'b0;
        chk("bp_b_valid", 32'(b_valid), 32'd1);
        $display("WR (B held) addr=00000010 data=0badf00d");
        do_read(32'h0C, 32'h11BB33DD, 2'b00);
        chk("bp_b_still", 32'(b_valid), 32'd1);
        ar_valid = 1'b1; ar_addr = 32'h04;
        tick();
        ar_valid = 1'b0;
        held = r_data;
        chk("hold_first_data", held, 32'hDEADAAEF);
        for (int i = 0; i < 5; i++) begin
            chk("hold_r_valid", 32'(r_valid), 32'd1);
            chk("hold_r_data", r_data, 32'hDEADAAEF);
            chk("hold_r_resp", 32'(r_resp), 32'd0);
            chk("hold_ar_ready", 32'(ar_ready), 32'd0);
            tick();
        end
        $display("RD (R held 5 cycles) addr=00000004 r_data=%h", r_data);
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        chk("hold_r_done", 32'(r_valid), 32'd0);
        chk("bp_b_after_r", 32'(b_valid), 32'd1);
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        chk("bp_b_done", 32'(b_valid), 32'd0);
        do_read(32'h10, 32'h0BADF00D, 2'b00);

        // Reset while in W_ADDR and R_DATA
        aw_valid = 1'b1; aw_addr = 32'h00; ar_valid = 1'b1; ar_addr = 32'h04;
        tick();
        aw_valid = 1'b0; ar_valid = 1'b0;
        chk("pre_rst_w_ready", 32'(w_ready), 32'd1);
        chk("pre_rst_aw_ready", 32'(aw_ready), 32'd0);
        chk("pre_rst_r_valid", 32'(r_valid), 32'd1);
        #2 areset_n = 1'b0;
        #1;
        chk("mid_rst_aw_ready", 32'(aw_ready), 32'd0);
        chk("mid_rst_w_ready", 32'(w_ready), 32'd0);
        chk("mid_rst_ar_ready", 32'(ar_ready), 32'd0);
        chk("mid_rst_b_valid", 32'(b_valid), 32'd0);
        chk("mid_rst_b_resp", 32'(b_resp), 32'd0);
        chk("mid_rst_r_valid", 32'(r_valid), 32'd0);
        chk("mid_rst_r_data", r_data, 32'd0);
        chk("mid_rst_r_resp", 32'(r_resp), 32'd0);
        $display("RESET asserted mid-transaction");
        tick();
        areset_n = 1'b1;
        w_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_no_b", 32'(b_valid), 32'd0);
            chk("post_rst_no_r", 32'(r_valid), 32'd0);
        end
        for (int i = 0; i < 16; i++) begin
            do_read(32'(i * 4), 32'd0, 2'b00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_slave_mem.md
AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

Interface
REQ-001 SHALL have parameter DATA_BITS, default 32, data width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_BITS, default 32, byte-address width.
REQ-003 SHALL have parameter DEPTH, default 16, number of DATA_BITS-wide storage words (power of 2).
REQ-004 SHALL have port aclk, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port areset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports aw_valid (input, 1), aw_ready (output, 1) and aw_addr (input, ADDR_BITS): the write-address handshake and byte address.
REQ-007 SHALL have ports w_valid (input, 1), w_ready (output, 1), w_data (input, DATA_BITS) and w_strb (input, DATA_BITS/8): the write-data handshake, data and byte enables.
REQ-008 SHALL have ports b_valid (output, 1), b_ready (input, 1) and b_resp (output, 2): the write response.
REQ-009 SHALL have ports ar_valid (input, 1), ar_ready (output, 1) and ar_addr (input, ADDR_BITS): the read-address handshake and byte address.
REQ-010 SHALL have ports r_valid (output, 1), r_ready (input, 1), r_data (output, DATA_BITS) and r_resp (output, 2): the read data and response.

Function
REQ-011 SHALL treat a handshake as valid && ready high on the same rising edge; single-beat transfers only.
REQ-012 SHALL compute word index = addr >> log2(DATA_BITS/8); an index >= DEPTH is out of range.
REQ-013 SHALL respond OKAY=2'b00 for in-range accesses and SLVERR=2'b10 for out-of-range accesses.
REQ-014 SHALL implement the write FSM W_IDLE, W_ADDR, W_DATA, W_RESP, with aw_ready=1 in W_IDLE/W_DATA, w_ready=1 in W_IDLE/W_ADDR, and 0 otherwise.
REQ-015 SHALL transition from W_IDLE on AW and W both -> W_RESP, AW only -> W_ADDR (latch addr), W only -> W_DATA (latch data/strb).
REQ-016 SHALL transition W_ADDR on W -> W_RESP and W_DATA on AW -> W_RESP.
REQ-017 SHALL commit the write on the edge that completes both handshakes, updating only bytes with w_strb=1; an out-of-range write is dropped.
REQ-018 SHALL assert b_valid only in W_RESP (one cycle after commit), hold b_resp stable, and return to W_IDLE on b_ready.
REQ-019 SHALL implement the read FSM R_IDLE (ar_ready=1) and R_DATA (ar_ready=0, r_valid=1).
REQ-020 SHALL register r_data/r_resp on the AR handshake, with 1-cycle latency; out-of-range reads return r_data=0.
REQ-021 SHALL hold r_data and r_resp stable while r_valid && !r_ready, and return to R_IDLE on the r_ready handshake.
REQ-022 SHALL return the old word when a read samples the same word on the edge a write commits.
REQ-023 SHALL run the read and write FSMs independently and concurrently.

Reset
REQ-024 SHALL, while areset_n=0, force both FSMs to IDLE, all ready/valid outputs to 0, b_resp/r_resp/r_data to 0 and all storage words to 0.
REQ-025 SHALL abort any operation in progress on reset mid-transaction, with no partial write committed and no response issued after reset release.

Structure
REQ-026 SHALL place the resp codes (OKAY, SLVERR) and the write/read state enums in shared package axi_pkg.
REQ-027 SHALL place storage in sub-module axi_slave_regfile (byte-strobed write port, one synchronous-capture read port, async reset).

Verification
REQ-028 SHALL check that AW 0x4 and W 0xDEADBEEF (strb 4'hF) in the same cycle give b_valid next cycle with b_resp=00, and that a later read of 0x4 returns 0xDEADBEEF with OKAY.
REQ-029 SHALL check that W arriving 3 cycles before AW 0x8 leaves aw_ready=1/w_ready=0 while waiting and produces exactly one B, and that a read of 0x8 returns the data.
REQ-030 SHALL check that writing 0x11223344 then 0xAABBCCDD with strb 4'b0101 at 0xC makes a read return 0x11BB33DD.
REQ-031 SHALL check that a write or read at 0x40 (DEPTH=16) gives b_resp=10, r_resp=10 and r_data=0, with storage unchanged.
REQ-032 SHALL check that holding r_ready=0 for 5 cycles keeps r_valid/r_data stable and ar_ready=0, and that B back-pressure does not stall reads.
REQ-033 SHALL check that areset_n dropped while in W_ADDR and R_DATA makes all outputs 0 immediately with no B/R after release and storage all 0.
